// File: rtl/cpu_pkg.sv
// Shared fetch-unit types: state encoding, bus widths and the NOP opcode.
// Pure declarations, no logic, no timing.
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int INSN_W = 8;
    localparam logic [INSN_W-1:0] NOP = 8'h00;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INSN_W-1:0] insn_t;

    typedef enum logic [2:0] {
        RST,
        RUN,
        XFER,
        DMAW,
        DMA
    } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Memory/DMA bus between the fetch unit (master) and memory plus DMA arbiter side (slave).
// Memory read data is valid one cycle after mem_rd; dma_req is a level held until dma_grant.
interface instruction_fetch_if;
    import cpu_pkg::*;

    addr_t mem_addr;
    logic  mem_rd;
    insn_t mem_data;
    logic  dma_req;
    logic  dma_grant;

    modport master (
        output mem_addr,
        output mem_rd,
        output dma_grant,
        input  mem_data,
        input  dma_req
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  dma_grant,
        output mem_data,
        output dma_req
    );
endinterface

// File: rtl/pc_pair.sv
// PC/RA register pair: flip swaps roles, load writes the post-flip active register, increment hits the fetched one.
// pc_next is combinational (same cycle); registers update on the next edge; no backpressure.
module pc_pair
    import cpu_pkg::*;
#(
    parameter addr_t RESET_VECTOR = 16'h0000
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  inc,
    input  logic  flip,
    input  logic  load,
    input  addr_t load_value,
    output addr_t pc_out,
    output addr_t pc_next,
    output logic  flag_pcraflip
);
    addr_t reg_a;
    addr_t reg_b;
    addr_t a_nxt;
    addr_t b_nxt;
    logic  sel;
    logic  sel_nxt;

    // The increment belongs to the register that was just fetched from (pre-flip);
    // the load goes to whichever register is active after the flip and wins on a collision.
    always_comb begin
        sel_nxt = sel ^ (en & flip);
        a_nxt   = reg_a;
        b_nxt   = reg_b;
        if (inc) begin
            if (sel) b_nxt = reg_b + addr_t'(1);
            else     a_nxt = reg_a + addr_t'(1);
        end
        if (en && load) begin
            if (sel_nxt) b_nxt = load_value;
            else         a_nxt = load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a <= RESET_VECTOR;
            reg_b <= RESET_VECTOR;
            sel   <= 1'b0;
        end else begin
            reg_a <= a_nxt;
            reg_b <= b_nxt;
            sel   <= sel_nxt;
        end
    end

    assign pc_out        = sel ? reg_b : reg_a;
    assign pc_next       = sel_nxt ? b_nxt : a_nxt;
    assign flag_pcraflip = sel;
endmodule

// File: rtl/instruction_fetch.sv
// CPU fetch front end: owns PC/RA, issues opcode fetches, hands the bus to DMA; PC-to-instruction latency 1 cycle.
// Stalls fetch for one XFER cycle on suppress_req_n=0 and for DMAW+DMA while dma_req is held.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter addr_t RESET_VECTOR = 16'h0000,
    parameter int    RESET_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                suppress_req_n,
    input  logic                pc_load,
    input  addr_t               pc_load_value,
    input  logic                pcra_flip,
    instruction_fetch_if.master bus,
    output insn_t               instruction,
    output logic                bus_request,
    output logic                fetch_suppress,
    output logic                flag_pcraflip,
    output logic                flag_reset,
    output addr_t               pc_out
);
    localparam logic [3:0] CNT_LAST = 4'(RESET_CYCLES - 1);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [3:0]   rst_cnt;
    logic         mem_rd_q;
    addr_t        mem_addr_q;
    logic         dma_grant_q;
    logic         fetch_valid;
    addr_t        pc_next;

    pc_pair #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_pair (
        .clk           (clk),
        .reset         (reset),
        .en            (state != RST),
        .inc           (state == RUN),
        .flip          (pcra_flip),
        .load          (pc_load),
        .load_value    (pc_load_value),
        .pc_out        (pc_out),
        .pc_next       (pc_next),
        .flag_pcraflip (flag_pcraflip)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            RST:  if (rst_cnt == CNT_LAST) state_nxt = RUN;
            RUN: begin
                if (!suppress_req_n)  state_nxt = XFER;
                else if (bus.dma_req) state_nxt = DMAW;
            end
            XFER: state_nxt = bus.dma_req ? DMAW : RUN;
            DMAW: state_nxt = DMA;
            DMA:  if (!bus.dma_req) state_nxt = RUN;
            default: state_nxt = RST;
        endcase
    end

    // Bus outputs are registered from the next state so they are valid for the whole cycle
    // of that state; fetch_suppress lags one cycle to sit beside the NOP that XFER leaves behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RST;
            rst_cnt        <= '0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
            fetch_valid    <= 1'b0;
            bus_request    <= 1'b1;
            fetch_suppress <= 1'b1;
            dma_grant_q    <= 1'b0;
            flag_reset     <= 1'b1;
        end else begin
            state          <= state_nxt;
            rst_cnt        <= (state == RST) ? rst_cnt + 4'd1 : '0;
            mem_rd_q       <= (state_nxt == RUN);
            mem_addr_q     <= (state_nxt == RUN) ? pc_next : '0;
            fetch_valid    <= mem_rd_q;
            bus_request    <= (state_nxt != DMA);
            fetch_suppress <= (state != XFER);
            dma_grant_q    <= (state_nxt == DMA);
            flag_reset     <= (state_nxt == RST);
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.dma_grant = dma_grant_q;
    assign instruction   = fetch_valid ? bus.mem_data : NOP;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written DMA/flip/reset sequences,
// then randomized traffic against a cycle-level reference model.
module tb_instruction_fetch;
    import cpu_pkg::*;

    localparam logic [15:0] RV = 16'h0100;
    localparam int          RC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        suppress_req_n = 1'b1;
    logic        pc_load = 1'b0;
    logic        pcra_flip = 1'b0;
    logic [15:0] pc_load_value = 16'h0000;
    logic [7:0]  instruction;
    logic        bus_request;
    logic        fetch_suppress;
    logic        flag_pcraflip;
    logic        flag_reset;
    logic [15:0] pc_out;

    instruction_fetch_if bus();

    instruction_fetch #(
        .RESET_VECTOR (RV),
        .RESET_CYCLES (RC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .suppress_req_n (suppress_req_n),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .pcra_flip      (pcra_flip),
        .bus            (bus),
        .instruction    (instruction),
        .bus_request    (bus_request),
        .fetch_suppress (fetch_suppress),
        .flag_pcraflip  (flag_pcraflip),
        .flag_reset     (flag_reset),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous memory: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= memf(bus.mem_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    // Reference model: reset countdown, pending-transfer flag, DMA phase (0 none, 1 dead, 2 granted),
    // the two PC registers by index and the previous cycle's fetch.
    int          cd = RC;
    bit          xfer = 1'b0;
    int          dph = 0;
    logic [15:0] pcm [2];
    bit          act = 1'b0;
    bit          pf = 1'b0;
    bit          px = 1'b0;
    logic [15:0] paddr = 16'h0000;

    function automatic bit m_fetching();
        return (cd == 0) && !xfer && (dph == 0);
    endfunction

    task automatic model_step(input logic r, input logic sn, input logic ld, input logic fl,
                              input logic dr, input logic [15:0] v);
        bit f;
        bit old;
        f = m_fetching();
        if (r) begin
            cd = RC; xfer = 1'b0; dph = 0; act = 1'b0;
            pcm[0] = RV; pcm[1] = RV;
            pf = 1'b0; px = 1'b0; paddr = 16'h0000;
            return;
        end
        pf = f; paddr = pcm[act]; px = xfer;
        if (cd > 0) begin
            cd--;
            return;
        end
        old = act;
        if (fl) act = !act;
        if (f)  pcm[old] = pcm[old] + 16'd1;
        if (ld) pcm[act] = v;
        if (f) begin
            if (!sn)     xfer = 1'b1;
            else if (dr) dph = 1;
        end else if (xfer) begin
            xfer = 1'b0;
            if (dr) dph = 1;
        end else if (dph == 1) begin
            dph = 2;
        end else if (dph == 2 && !dr) begin
            dph = 0;
        end
    endtask

    task automatic check_model();
        bit f;
        f = m_fetching();
        chk16("mem_addr", bus.mem_addr, f ? pcm[act] : 16'h0000);
        chk1("mem_rd", bus.mem_rd, f);
        chk8("instruction", instruction, pf ? memf(paddr) : 8'h00);
        chk1("fetch_suppress", fetch_suppress, !px);
        chk1("bus_request", bus_request, dph != 2);
        chk1("dma_grant", bus.dma_grant, dph == 2);
        chk1("flag_reset", flag_reset, cd > 0);
        chk1("flag_pcraflip", flag_pcraflip, act);
        chk16("pc_out", pc_out, pcm[act]);
    endtask

    task automatic cycle(input logic r, input logic sn, input logic ld, input logic fl,
                         input logic dr, input logic [15:0] v);
        reset = r; suppress_req_n = sn; pc_load = ld; pcra_flip = fl;
        bus.dma_req = dr; pc_load_value = v;
        @(posedge clk);
        model_step(r, sn, ld, fl, dr, v);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic        rst;
        logic        sn;
        logic        ld;
        logic [15:0] val;
        logic [15:0] e_addr;
        logic        e_rd;
        logic        e_iv;
        logic [15:0] e_ia;
        logic        e_fs;
        logic        e_fr;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic dq;
        bus.dma_req = 1'b0;

        // Reset release, free run across FFFF->0000, one XFER at 0010.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0101, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0101};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b1, 16'h0101, 1'b1, 1'b0, 16'hFFFE};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'hFFFF};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0010};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0011};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0011};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0012, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b0, 16'h0012};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].sn, tbl[i].ld, 1'b0, 1'b0, tbl[i].val);
            chk16($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
            chk1($sformatf("v%0d mem_rd", i), bus.mem_rd, tbl[i].e_rd);
            chk8($sformatf("v%0d instruction", i), instruction,
                 tbl[i].e_iv ? memf(tbl[i].e_ia) : 8'h00);
            chk1($sformatf("v%0d fetch_suppress", i), fetch_suppress, tbl[i].e_fs);
            chk1($sformatf("v%0d flag_reset", i), flag_reset, tbl[i].e_fr);
            chk16($sformatf("v%0d pc_out", i), pc_out, tbl[i].e_pc);
        end

        // DMA request while fetching 0020.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020);
        chk16("dma pre addr", bus.mem_addr, 16'h0020);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk1("dma dead rd", bus.mem_rd, 1'b0);
        chk1("dma dead grant", bus.dma_grant, 1'b0);
        chk16("dma dead pc", pc_out, 16'h0021);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
            chk1("dma grant", bus.dma_grant, 1'b1);
            chk1("dma bus_request", bus_request, 1'b0);
            chk16("dma addr", bus.mem_addr, 16'h0000);
            chk16("dma pc hold", pc_out, 16'h0021);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk1("dma release grant", bus.dma_grant, 1'b0);
        chk16("dma resume addr", bus.mem_addr, 16'h0021);

        // Set up A=0030 active, B=0500 while the bus is granted (no increments there).
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0500);
        chk1("dma flip applied", flag_pcraflip, 1'b1);
        chk16("dma load applied", pc_out, 16'h0500);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0030);
        chk16("setup addr", bus.mem_addr, 16'h0030);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0200);
        chk1("flip+load flag", flag_pcraflip, 1'b1);
        chk16("flip+load addr", bus.mem_addr, 16'h0200);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk16("flip back A", bus.mem_addr, 16'h0031);

        // Reset while granted.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk1("pre-reset grant", bus.dma_grant, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk1("rst dma grant", bus.dma_grant, 1'b0);
        chk1("rst dma bus_request", bus_request, 1'b1);
        chk16("rst dma pc", pc_out, RV);
        for (int i = 0; i < RC; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Reset during XFER.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk1("xfer rd", bus.mem_rd, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk1("rst xfer fetch_suppress", fetch_suppress, 1'b1);
        chk8("rst xfer instruction", instruction, 8'h00);
        chk1("rst xfer flag_reset", flag_reset, 1'b1);

        // Randomized traffic.
        dq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!dq) dq = ($urandom_range(0, 24) == 0);
            else if (bus.dma_grant && $urandom_range(0, 3) == 0) dq = 1'b0;
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, dq, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
